// File: rtl/bist_pkg.sv
// Shared definitions for the ALU BIST stimulus controller and its signature
// compactor: LFSR polynomial taps, the LFSR step function, default seeds and
// the controller state encoding.
package bist_pkg;

  localparam int LFSR_W = 32;

  // Feedback taps of the 32-bit Fibonacci LFSR used by both generator and MISR.
  localparam int TAP_3 = 31;
  localparam int TAP_2 = 21;
  localparam int TAP_1 = 1;
  localparam int TAP_0 = 0;

  // SEED_A_DEFAULT matches the compactor's reseed value.
  localparam logic [LFSR_W-1:0] SEED_A_DEFAULT = 32'h0000ACE1;
  localparam logic [LFSR_W-1:0] SEED_B_DEFAULT = 32'h1D872B41;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // One shift of the LFSR: feedback enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr32_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_3] ^ s[TAP_2] ^ s[TAP_1] ^ s[TAP_0]};
  endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// 32-bit pattern LFSR with synchronous seed load.
// Ports:
//   clk      clock
//   rst      synchronous active-low reset (state cleared to 0)
//   load     load seed this edge (has priority over advance)
//   advance  step the LFSR this edge
//   seed     value loaded by load
//   state    current LFSR contents
module bist_lfsr32
  import bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= lfsr32_next(state);
    end
  end

endmodule

// File: rtl/bist_tpg_ctrl.sv
// Stimulus-side BIST controller for the primary ALU. A run reseeds the
// compactor (misr_rst_n pulse), presents PATTERN_COUNT LFSR operand pairs with
// cycling opcodes, frames the ALU response window with test_en (delayed by the
// ALU latency) and finishes with a one-cycle test_done compare strobe.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   start        begin a run (only honoured in IDLE)
//   abort        cancel a busy run without issuing test_done
//   op_a, op_b   ALU operands
//   alu_ctrl     ALU opcode, cycles 0..NUM_OPS-1
//   test_en      compactor accumulate enable
//   test_done    compactor compare strobe
//   misr_rst_n   compactor reseed, active low
//   busy         run in progress
module bist_tpg_ctrl
  import bist_pkg::*;
#(
  parameter int                PATTERN_COUNT = 256,
  parameter int                NUM_OPS       = 10,
  parameter int                PIPE_LAT      = 0,
  parameter logic [LFSR_W-1:0] SEED_A        = SEED_A_DEFAULT,
  parameter logic [LFSR_W-1:0] SEED_B        = SEED_B_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [LFSR_W-1:0] op_a,
  output logic [LFSR_W-1:0] op_b,
  output logic [3:0]        alu_ctrl,
  output logic              test_en,
  output logic              test_done,
  output logic              misr_rst_n,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(PATTERN_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_PAT = CNT_W'(PATTERN_COUNT - 1);
  localparam logic [3:0]       LAST_OP  = 4'(NUM_OPS - 1);
  localparam logic [1:0]       LAST_DRN = 2'(PIPE_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] pat_cnt;
  logic [1:0]       drain_cnt;
  logic             run_q;      // high exactly during RUN cycles
  logic             kill;       // abort is only meaningful while busy
  logic             last_pat;
  logic             lfsr_load;
  logic             lfsr_adv;

  assign kill     = abort && (state != IDLE);
  assign last_pat = (pat_cnt == LAST_PAT);

  // Seeds land on the LOAD->RUN edge so the first RUN cycle shows them. The
  // final RUN edge does not step, so DRAIN holds the last presented pattern.
  assign lfsr_load = (state == LOAD) && !abort;
  assign lfsr_adv  = (state == RUN) && !abort && !last_pat;

  bist_lfsr32 u_lfsr_a (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (SEED_A),
    .state   (op_a)
  );

  bist_lfsr32 u_lfsr_b (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (SEED_B),
    .state   (op_b)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pat_cnt    <= '0;
      drain_cnt  <= '0;
      alu_ctrl   <= '0;
      run_q      <= 1'b0;
      test_done  <= 1'b0;
      busy       <= 1'b0;
      misr_rst_n <= 1'b1;
    end else if (kill) begin
      // Operands and opcode deliberately hold their current values.
      state      <= IDLE;
      pat_cnt    <= '0;
      drain_cnt  <= '0;
      run_q      <= 1'b0;
      test_done  <= 1'b0;
      busy       <= 1'b0;
      misr_rst_n <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          test_done <= 1'b0;
          busy      <= 1'b0;
          if (start) begin
            state      <= LOAD;
            misr_rst_n <= 1'b0;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          misr_rst_n <= 1'b1;
          alu_ctrl   <= '0;
          pat_cnt    <= '0;
          run_q      <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          pat_cnt <= pat_cnt + 1'b1;
          if (last_pat) begin
            run_q     <= 1'b0;
            drain_cnt <= '0;
            if (PIPE_LAT == 0) begin
              state     <= DONE;
              test_done <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            alu_ctrl <= (alu_ctrl == LAST_OP) ? 4'd0 : alu_ctrl + 4'd1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == LAST_DRN) begin
            state     <= DONE;
            test_done <= 1'b1;
          end
        end
        DONE: begin
          test_done <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // test_en is run_q delayed by the ALU latency so the compactor accumulates
  // exactly the results belonging to the presented patterns.
  generate
    if (PIPE_LAT == 0) begin : g_no_delay
      assign test_en = run_q;
    end else begin : g_delay
      logic [PIPE_LAT-1:0] en_pipe;

      always_ff @(posedge clk) begin
        if (!rst || kill) begin
          en_pipe <= '0;
        end else begin
          en_pipe <= (en_pipe << 1) | PIPE_LAT'(run_q);
        end
      end

      assign test_en = en_pipe[PIPE_LAT-1];
    end
  endgenerate

endmodule
